// File: rtl/delay_window_checker.sv
// Measures how many cycles after a start the observed value first equals the
// captured expected value, and grades that arrival against a legal window.
module delay_window_checker #(
  parameter int WIDTH   = 4,
  parameter int MIN_DLY = 2,
  parameter int MAX_DLY = 17,
  parameter int CW      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] obs_value,
  input  logic             obs_known,
  input  logic [WIDTH-1:0] exp_value,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail_early,
  output logic             fail_late,
  output logic [CW-1:0]    measured,
  output logic [7:0]       pass_cnt,
  output logic [7:0]       fail_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  localparam logic [CW-1:0] MIN_C = CW'(MIN_DLY);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_DLY);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             pass_q, pass_d;
  logic             early_q, early_d;
  logic             late_q, late_d;
  logic [CW-1:0]    meas_q, meas_d;
  logic [7:0]       pass_cnt_q, pass_cnt_d;
  logic [7:0]       fail_cnt_q, fail_cnt_d;

  logic [CW-1:0]    cnt_inc;
  logic             match;

  // The arrival cycle is the value the counter takes on this edge, graded
  // against the inputs present just before the edge.
  assign cnt_inc = cnt_q + CW'(1);
  assign match   = obs_known && (obs_value == exp_q);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    pass_d     = pass_q;
    early_d    = early_q;
    late_d     = late_q;
    meas_d     = meas_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          exp_d   = exp_value;
          cnt_d   = '0;
          pass_d  = 1'b0;
          early_d = 1'b0;
          late_d  = 1'b0;
          meas_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        // A match on the last legal cycle wins over the timeout.
        if (match) begin
          meas_d  = cnt_inc;
          state_d = S_REPORT;
          if (cnt_inc < MIN_C) begin
            early_d    = 1'b1;
            fail_cnt_d = (fail_cnt_q == 8'hFF) ? fail_cnt_q : fail_cnt_q + 8'd1;
          end else begin
            pass_d     = 1'b1;
            pass_cnt_d = (pass_cnt_q == 8'hFF) ? pass_cnt_q : pass_cnt_q + 8'd1;
          end
        end else if (cnt_inc == MAX_C) begin
          late_d     = 1'b1;
          meas_d     = MAX_C;
          state_d    = S_REPORT;
          fail_cnt_d = (fail_cnt_q == 8'hFF) ? fail_cnt_q : fail_cnt_q + 8'd1;
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      exp_q      <= '0;
      pass_q     <= 1'b0;
      early_q    <= 1'b0;
      late_q     <= 1'b0;
      meas_q     <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      pass_q     <= pass_d;
      early_q    <= early_d;
      late_q     <= late_d;
      meas_q     <= meas_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign busy       = (state_q == S_WAIT);
  assign done       = (state_q == S_REPORT);
  assign pass       = pass_q;
  assign fail_early = early_q;
  assign fail_late  = late_q;
  assign measured   = meas_q;
  assign pass_cnt   = pass_cnt_q;
  assign fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_delay_window_checker.sv
// Directed bench for delay_window_checker: expected verdicts are queued at
// start and compared when done pulses.
module tb_delay_window_checker;

  localparam int WIDTH   = 4;
  localparam int MIN_DLY = 2;
  localparam int MAX_DLY = 17;
  localparam int CW      = 8;

  typedef struct {
    logic       pass;
    logic       early;
    logic       late;
    int         meas;
    logic [7:0] pass_cnt;
    logic [7:0] fail_cnt;
  } verdict_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] obs_value;
  logic             obs_known;
  logic [WIDTH-1:0] exp_value;
  logic             busy, done, pass, fail_early, fail_late;
  logic [CW-1:0]    measured;
  logic [7:0]       pass_cnt, fail_cnt;

  verdict_t   sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] m_pass_cnt = '0;
  logic [7:0] m_fail_cnt = '0;

  delay_window_checker #(
    .WIDTH(WIDTH), .MIN_DLY(MIN_DLY), .MAX_DLY(MAX_DLY), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .obs_value(obs_value),
    .obs_known(obs_known), .exp_value(exp_value), .busy(busy), .done(done),
    .pass(pass), .fail_early(fail_early), .fail_late(fail_late),
    .measured(measured), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference grading: m is the first matching arrival cycle, 0 if none.
  function automatic verdict_t model(input int m);
    verdict_t v;
    v.pass = 1'b0; v.early = 1'b0; v.late = 1'b0;
    if (m != 0 && m <= MAX_DLY) begin
      v.meas = m;
      if (m < MIN_DLY) begin
        v.early = 1'b1;
        if (m_fail_cnt != 8'hFF) m_fail_cnt = m_fail_cnt + 8'd1;
      end else begin
        v.pass = 1'b1;
        if (m_pass_cnt != 8'hFF) m_pass_cnt = m_pass_cnt + 8'd1;
      end
    end else begin
      v.late = 1'b1;
      v.meas = MAX_DLY;
      if (m_fail_cnt != 8'hFF) m_fail_cnt = m_fail_cnt + 8'd1;
    end
    v.pass_cnt = m_pass_cnt;
    v.fail_cnt = m_fail_cnt;
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_early"}, 32'(fail_early), 0);
    check({tag, "_late"}, 32'(fail_late), 0);
    check({tag, "_meas"}, 32'(measured), 0);
    check({tag, "_pcnt"}, 32'(pass_cnt), 0);
    check({tag, "_fcnt"}, 32'(fail_cnt), 0);
  endtask

  // One measurement: match_at = arrival cycle with a known matching value
  // (0 = never); other cycles drive noise_val with noise_known.
  task automatic run(input string tag, input logic [WIDTH-1:0] e, input int match_at,
                     input logic [WIDTH-1:0] noise_val, input logic noise_known,
                     input int restart_at, input int abort_at, input bit detail);
    verdict_t v;
    bit got;
    got = 1'b0;
    start = 1'b1; exp_value = e; obs_known = 1'b0; obs_value = noise_val;
    if (abort_at == 0) sb_q.push_back(model(match_at));
    step();
    start = 1'b0; exp_value = ~e;
    if (detail) begin
      check({tag, "_acc_busy"}, 32'(busy), 1);
      check({tag, "_acc_meas"}, 32'(measured), 0);
    end
    for (int n = 1; n <= MAX_DLY + 3 && !got; n++) begin
      start     = (n == restart_at);
      obs_known = (n == match_at) ? 1'b1 : noise_known;
      obs_value = (n == match_at) ? e : noise_val;
      if (n == abort_at) begin
        reset = 1'b1;
        step();
        reset = 1'b0; start = 1'b0; obs_known = 1'b0;
        m_pass_cnt = '0; m_fail_cnt = '0;
        check_all_zero({tag, "_abort"});
        step();
        check({tag, "_abort_idle"}, 32'(busy), 0);
        return;
      end
      step();
      if (done) begin
        got = 1'b1;
        v = sb_q.pop_front();
        check({tag, "_cycle"}, 32'(n), 32'(v.meas));
        check({tag, "_pass"}, 32'(pass), 32'(v.pass));
        check({tag, "_early"}, 32'(fail_early), 32'(v.early));
        check({tag, "_late"}, 32'(fail_late), 32'(v.late));
        check({tag, "_meas"}, 32'(measured), 32'(v.meas));
        check({tag, "_pcnt"}, 32'(pass_cnt), 32'(v.pass_cnt));
        check({tag, "_fcnt"}, 32'(fail_cnt), 32'(v.fail_cnt));
        check({tag, "_busy_rep"}, 32'(busy), 0);
      end else if (detail) begin
        check({tag, "_busy_wait"}, 32'(busy), 1);
        check({tag, "_flags_wait"}, 32'({pass, fail_early, fail_late}), 0);
      end
    end
    if (!got) check({tag, "_timeout_done"}, 32'(done), 1);
    start = 1'b0; obs_known = 1'b0;
    step();
    check({tag, "_done_drop"}, 32'(done), 0);
    if (detail) begin
      check({tag, "_idle_busy"}, 32'(busy), 0);
      check({tag, "_held_pass"}, 32'(pass), 32'(v.pass));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; obs_value = '0; obs_known = 1'b0; exp_value = '0;
    step();
    step();
    check_all_zero("reset");
    reset = 1'b0; start = 1'b0;
    step();
    check("post_reset_idle", 32'(busy), 0);

    // Matching value present but unknown until cycle 9.
    run("pass9", 4'h5, 9, 4'h5, 1'b0, 0, 0, 1'b1);
    run("early1", 4'hA, 1, 4'hA, 1'b0, 0, 0, 1'b1);
    run("late", 4'h5, 0, 4'h3, 1'b1, 0, 0, 1'b1);
    run("pass17", 4'h5, 17, 4'h3, 1'b1, 0, 0, 1'b1);
    run("pass_min", 4'hC, 2, 4'h0, 1'b1, 0, 0, 1'b1);
    run("restart", 4'h6, 11, 4'h0, 1'b1, 5, 0, 1'b1);
    run("abort", 4'h7, 0, 4'h7, 1'b0, 0, 6, 1'b1);
    run("after_abort", 4'h7, 12, 4'h1, 1'b1, 0, 0, 1'b1);

    for (int i = 0; i < 300; i++) run("sat", 4'(i), 3, 4'(i + 1), 1'b1, 0, 0, 1'b0);
    check("sat_pass_cnt", 32'(pass_cnt), 255);
    check("sat_fail_cnt", 32'(fail_cnt), 0);
    check("sb_empty", 32'(sb_q.size()), 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
